// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types and constants for the f1 truth-table sweep controller
package f1_pkg;

    localparam int unsigned VEC_W = 4;
    localparam int unsigned VEC_N = 16;

    localparam logic [VEC_N-1:0] F1_EXP_TT = 16'hDC51;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/f1_settle_timer.sv
// rtl/f1_settle_timer.sv - 8-bit per-vector settle down-counter with load and expire
module f1_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic       expire
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (load) begin
            count_d = load_val;
        end else if (en && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expire on the last counted cycle so the owner leaves its wait state exactly on time.
    assign expire = en && (count_q == 8'd1);

endmodule

// File: rtl/f1_sweep_ctrl.sv
// rtl/f1_sweep_ctrl.sv - f1 exhaustive sweep sequencer; F1_SELFCHECK_EN adds the golden-table comparator
module f1_sweep_ctrl
    import f1_pkg::*;
#(
    parameter int unsigned      SETTLE_CYCLES = 2,
    parameter logic [VEC_N-1:0] EXP_TT        = F1_EXP_TT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             f_out,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             a2,
    output logic             b2,
    output logic             c2,
    output logic             d2,
    output logic             busy,
    output logic             done,
    output logic [VEC_N-1:0] tt,
    output logic             mismatch
);

    localparam logic [7:0]       SETTLE_VAL = SETTLE_CYCLES[7:0];
    localparam logic [VEC_W-1:0] LAST_IDX   = 4'd15;

    state_t           state_q;
    logic [VEC_W-1:0] idx_q;
    logic [VEC_W-1:0] rails_q;
    logic [VEC_W-1:0] rails_n_q;
    logic             busy_q;
    logic             done_q;
    logic [VEC_N-1:0] tt_q;

    logic timer_load;
    logic timer_en;
    logic timer_expire;
    logic last_sample;

    assign timer_load  = (state_q == APPLY) && !abort && (SETTLE_CYCLES != 0);
    assign timer_en    = (state_q == SETTLE);
    assign last_sample = (state_q == SAMPLE) && !abort && (idx_q == LAST_IDX);

    f1_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (abort),
        .load     (timer_load),
        .load_val (SETTLE_VAL),
        .en       (timer_en),
        .expire   (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rails_q   <= '0;
            rails_n_q <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= APPLY;
                        idx_q     <= '0;
                        rails_q   <= '0;
                        rails_n_q <= '1;
                        tt_q      <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                APPLY, SETTLE, SAMPLE: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        idx_q     <= '0;
                        rails_q   <= '0;
                        rails_n_q <= '1;
                        busy_q    <= 1'b0;
                    end else if (state_q == APPLY) begin
                        state_q <= (SETTLE_CYCLES != 0) ? SETTLE : SAMPLE;
                    end else if (state_q == SETTLE) begin
                        if (timer_expire) begin
                            state_q <= SAMPLE;
                        end
                    end else begin
                        tt_q[idx_q] <= f_out;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // Rails move with idx on the same edge so both rails stay complementary.
                            state_q   <= APPLY;
                            idx_q     <= idx_q + 4'd1;
                            rails_q   <= idx_q + 4'd1;
                            rails_n_q <= ~(idx_q + 4'd1);
                        end
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    idx_q     <= '0;
                    rails_q   <= '0;
                    rails_n_q <= '1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef F1_SELFCHECK_EN
    logic mismatch_q;

    // Compare against the final table including the bit captured on this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            mismatch_q <= 1'b0;
        end else if (last_sample) begin
            mismatch_q <= ({f_out, tt_q[VEC_N-2:0]} != EXP_TT);
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_selfcheck;

    assign unused_selfcheck = (^EXP_TT) ^ last_sample;
    assign mismatch         = 1'b0;
`endif

    assign a  = rails_q[3];
    assign b  = rails_q[2];
    assign c  = rails_q[1];
    assign d  = rails_q[0];
    assign a2 = rails_n_q[3];
    assign b2 = rails_n_q[2];
    assign c2 = rails_n_q[1];
    assign d2 = rails_n_q[0];

    assign busy = busy_q;
    assign done = done_q;
    assign tt   = tt_q;

endmodule
